// File: rtl/rr_arbiter_8to3_if.sv
// rtl/rr_arbiter_8to3_if.sv - request/grant bundle between requesters and the 8:3 arbiter
interface rr_arbiter_8to3_if;
    logic [7:0] req;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       grant_start;

    // requester side: drives requests, observes the grant
    modport master (
        output req,
        input  grant_idx,
        input  grant_valid,
        input  grant_start
    );

    // arbiter side
    modport slave (
        input  req,
        output grant_idx,
        output grant_valid,
        output grant_start
    );
endinterface

// File: rtl/rr_arbiter_8to3.sv
// rtl/rr_arbiter_8to3.sv - registered round-robin arbiter, 8 requests to a 3-bit grant index
module rr_arbiter_8to3 #(
    parameter int MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               rst,
    rr_arbiter_8to3_if.slave   bus
);
    // hold counter must be able to reach MAX_HOLD; keep at least one bit for the unlimited case
    localparam int HCW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           r_state;
    logic [2:0]       r_ptr;
    logic [2:0]       r_grant_idx;
    logic             r_grant_valid;
    logic             r_grant_start;
    logic [HCW-1:0]   r_hold_cnt;

    logic [2:0]       w_winner;
    logic [2:0]       w_cand;
    logic             w_any;
    logic             w_hold_limit;
    logic             w_release;

    // cyclic priority search starting at r_ptr; scanning downward lets the closest index win last
    always_comb begin
        w_winner = r_ptr;
        w_cand   = '0;
        for (int i = 7; i >= 0; i--) begin
            w_cand = r_ptr + 3'(i);
            if (bus.req[w_cand]) begin
                w_winner = w_cand;
            end
        end
    end

    // release when the holder drops its request or has used up its hold allowance
    always_comb begin
        w_any        = |bus.req;
        w_hold_limit = (MAX_HOLD != 0) && (r_hold_cnt == HCW'(MAX_HOLD));
        w_release    = !bus.req[r_grant_idx] || w_hold_limit;
    end

    // grant state machine: idle, new grant, hold, handoff; all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_ptr         <= '0;
            r_grant_idx   <= '0;
            r_grant_valid <= 1'b0;
            r_grant_start <= 1'b0;
            r_hold_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state       <= GRANT;
                        r_grant_idx   <= w_winner;
                        r_grant_valid <= 1'b1;
                        r_grant_start <= 1'b1;
                        r_ptr         <= w_winner + 3'd1;
                        r_hold_cnt    <= HCW'(1);
                    end else begin
                        r_grant_start <= 1'b0;
                    end
                end
                GRANT: begin
                    if (!w_release) begin
                        r_grant_start <= 1'b0;
                        if (r_hold_cnt != {HCW{1'b1}}) begin
                            r_hold_cnt <= r_hold_cnt + HCW'(1);
                        end
                    end else if (w_any) begin
                        // handoff without an idle bubble; may re-grant the same requester
                        r_grant_idx   <= w_winner;
                        r_grant_valid <= 1'b1;
                        r_grant_start <= 1'b1;
                        r_ptr         <= w_winner + 3'd1;
                        r_hold_cnt    <= HCW'(1);
                    end else begin
                        r_state       <= IDLE;
                        r_grant_valid <= 1'b0;
                        r_grant_start <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant_idx   = r_grant_idx;
    assign bus.grant_valid = r_grant_valid;
    assign bus.grant_start = r_grant_start;

endmodule

// File: tb/tb_rr_arbiter_8to3.sv
// tb/tb_rr_arbiter_8to3.sv - scoreboard bench for rr_arbiter_8to3 against a behavioural model
module tb_rr_arbiter_8to3;
    localparam int MAX_HOLD = 4;

    logic clk;
    logic rst;
    int   checks;
    int   passes;
    int   cyc;

    typedef struct {
        int   idx;
        bit   valid;
        bit   start;
        int   tag;
    } exp_t;

    exp_t exp_q[$];

    // behavioural model state
    int m_idx;
    bit m_valid;
    int m_ptr;
    int m_held;
    bit m_start;

    rr_arbiter_8to3_if bus();

    rr_arbiter_8to3 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // one cycle of the reference: outputs after the coming edge given rst/req
    task automatic model_step(input bit r, input logic [7:0] rq);
        bit release_now;
        int w;
        if (r) begin
            m_idx = 0; m_valid = 0; m_start = 0; m_ptr = 0; m_held = 0;
            return;
        end
        release_now = !m_valid || !rq[m_idx] || (MAX_HOLD != 0 && m_held >= MAX_HOLD);
        if (!release_now) begin
            m_start = 0;
            m_held  = m_held + 1;
        end else if (rq != 8'h00) begin
            w = -1;
            for (int j = 0; j < 8; j++) begin
                if (w < 0 && rq[(m_ptr + j) % 8]) w = (m_ptr + j) % 8;
            end
            m_idx = w; m_valid = 1; m_start = 1; m_ptr = (w + 1) % 8; m_held = 1;
        end else begin
            m_valid = 0; m_start = 0;
        end
    endtask

    task automatic apply(input bit r, input logic [7:0] rq);
        exp_t e;
        @(negedge clk);
        rst     = r;
        bus.req = rq;
        model_step(r, rq);
        e.idx = m_idx; e.valid = m_valid; e.start = m_start; e.tag = cyc;
        exp_q.push_back(e);
    endtask

    task automatic repeat_apply(input int n, input bit r, input logic [7:0] rq);
        for (int k = 0; k < n; k++) apply(r, rq);
    endtask

    // monitor: after every edge, pop the expectation issued for it and compare
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks = checks + 1;
                if (int'(bus.grant_idx) == e.idx && bus.grant_valid == e.valid &&
                    bus.grant_start == e.start) begin
                    passes = passes + 1;
                end else begin
                    $display("FAIL grant@issue%0d: got idx=%0d valid=%0b start=%0b, expected idx=%0d valid=%0b start=%0b",
                             e.tag, bus.grant_idx, bus.grant_valid, bus.grant_start,
                             e.idx, e.valid, e.start);
                end
            end
        end
    end

    initial begin
        logic [7:0] rq;
        checks  = 0;
        passes  = 0;
        cyc     = 0;
        rst     = 1'b1;
        bus.req = 8'hFF;
        m_idx = 0; m_valid = 0; m_ptr = 0; m_held = 0; m_start = 0;

        // reset with all requests high, then first grant
        repeat_apply(2, 1, 8'hFF);
        apply(0, 8'hFF);

        // single requester, then drop
        apply(1, 8'h00);
        repeat_apply(3, 0, 8'h10);
        repeat_apply(2, 0, 8'h00);

        // rotation under full load, 4-cycle holds
        apply(1, 8'h00);
        repeat_apply(40, 0, 8'hFF);
        repeat_apply(2, 0, 8'h00);

        // wrap-around: leave ptr at 6, then requesters 0 and 1
        repeat_apply(2, 0, 8'h20);
        apply(0, 8'h00);
        repeat_apply(10, 0, 8'h03);
        apply(0, 8'h00);

        // back-to-back handoff 2 -> 5
        repeat_apply(2, 0, 8'h04);
        apply(0, 8'h24);
        repeat_apply(2, 0, 8'h20);
        apply(0, 8'h00);

        // solo timeout, then reset mid-hold and re-grant
        repeat_apply(13, 0, 8'h08);
        apply(1, 8'h08);
        repeat_apply(3, 0, 8'h08);

        // randomized traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0: rq = 8'($urandom);
                1: rq = 8'h01 << $urandom_range(0, 7);
                2: rq = 8'hFF;
                default: rq = 8'($urandom) & 8'($urandom);
            endcase
            apply(($urandom_range(0, 39) == 0), rq);
        end

        @(posedge clk);
        #2;
        checks = checks + 1;
        if (exp_q.size() == 0) begin
            passes = passes + 1;
        end else begin
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
